// File: rtl/btn_conditioner_pkg.sv
// Shared types and defaults for the push-button conditioner.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  localparam int DEF_NBTN    = 4;
  localparam int DEF_SMP_DIV = 100000;
  localparam int DEF_STABLE  = 8;
  localparam int DEF_REP_EN  = 1;
  localparam int DEF_REP_DLY = 500;
  localparam int DEF_REP_PER = 100;

  // Bits needed for a counter holding 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle: raw pins in, conditioned level/pulse/hold out.
interface btn_conditioner_if
  import btn_conditioner_pkg::*;
#(
  parameter int NBTN = DEF_NBTN
);
  logic [NBTN-1:0] BTNIN;
  logic [NBTN-1:0] BTNLVL;
  logic [NBTN-1:0] BTNOUT;
  logic [NBTN-1:0] BTNHOLD;

  modport master (output BTNIN, input BTNLVL, input BTNOUT, input BTNHOLD);
  modport slave  (input BTNIN, output BTNLVL, output BTNOUT, output BTNHOLD);
endinterface

// File: rtl/btn_conditioner_chan.sv
// One button channel: synchroniser, tick-sampled debouncer and
// press/auto-repeat pulse FSM with registered outputs.
module btn_conditioner_chan
  import btn_conditioner_pkg::*;
#(
  parameter int STABLE  = DEF_STABLE,
  parameter int REP_EN  = DEF_REP_EN,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_i,
  output logic lvl_o,
  output logic out_o,
  output logic hold_o
);

  localparam int DB_W = cnt_w(STABLE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE - 1);
  localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int REP_W = cnt_w(REP_MAX);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REP_DLY - 1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(REP_PER - 1);

  logic [1:0]       sync_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise, fall;
  btn_state_e       state_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic             out_q, hold_q;

  // Two-flop synchroniser; sync_q[1] is the only copy used downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], btn_i};
  end

  // Debounce: STABLE consecutive disagreeing tick samples flip the level.
  always_comb begin
    db_cnt_d = db_cnt_q;
    lvl_d    = lvl_q;
    if (tick_i) begin
      if (sync_q[1] == lvl_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        lvl_d    = ~lvl_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rise = lvl_d & ~lvl_q;
  assign fall = ~lvl_d & lvl_q;

  // Debounced level and its progress counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      lvl_q    <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      lvl_q    <= lvl_d;
    end
  end

  // Press/repeat FSM; a release always wins and silences the channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rep_cnt_q <= '0;
      out_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      out_q <= 1'b0;
      if (fall) begin
        state_q   <= ST_IDLE;
        rep_cnt_q <= '0;
        hold_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              out_q     <= 1'b1;
              rep_cnt_q <= '0;
              if (REP_EN != 0) state_q <= ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (tick_i) begin
              if (rep_cnt_q == DLY_LAST) begin
                out_q     <= 1'b1;
                rep_cnt_q <= '0;
                hold_q    <= 1'b1;
                state_q   <= ST_REPEAT;
              end else begin
                rep_cnt_q <= rep_cnt_q + REP_W'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (tick_i) begin
              if (rep_cnt_q == PER_LAST) begin
                out_q     <= 1'b1;
                rep_cnt_q <= '0;
              end else begin
                rep_cnt_q <= rep_cnt_q + REP_W'(1);
              end
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
            hold_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lvl_o  = lvl_q;
  assign out_o  = out_q;
  assign hold_o = hold_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button front end: shared sample tick plus one
// conditioning channel per button.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int NBTN    = DEF_NBTN,
  parameter int SMP_DIV = DEF_SMP_DIV,
  parameter int STABLE  = DEF_STABLE,
  parameter int REP_EN  = DEF_REP_EN,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input logic              CLK,
  input logic              RST_N,
  btn_conditioner_if.slave bus
);

  localparam int TICK_W = cnt_w(SMP_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SMP_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [NBTN-1:0]   lvl, out, hold;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  // Free-running sample divider shared by every channel.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    btn_conditioner_chan #(
      .STABLE (STABLE),
      .REP_EN (REP_EN),
      .REP_DLY(REP_DLY),
      .REP_PER(REP_PER)
    ) u_chan (
      .clk_i (CLK),
      .rst_ni(RST_N),
      .tick_i(tick),
      .btn_i (bus.BTNIN[i]),
      .lvl_o (lvl[i]),
      .out_o (out[i]),
      .hold_o(hold[i])
    );
  end

  assign bus.BTNLVL  = lvl;
  assign bus.BTNOUT  = out;
  assign bus.BTNHOLD = hold;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench: two conditioners (auto-repeat on / off) fed the same pins,
// compared every cycle against a tick-timestamp reference model.
module tb_btn_conditioner;
  import btn_conditioner_pkg::*;

  localparam int NB = 2;
  localparam int SD = 4;
  localparam int ST = 3;
  localparam int RD = 4;
  localparam int RP = 2;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b0;
  logic [NB-1:0] btnin = '0;

  btn_conditioner_if #(.NBTN(NB)) bus_rep ();
  btn_conditioner_if #(.NBTN(NB)) bus_sgl ();
  assign bus_rep.BTNIN = btnin;
  assign bus_sgl.BTNIN = btnin;

  btn_conditioner #(.NBTN(NB), .SMP_DIV(SD), .STABLE(ST), .REP_EN(1),
                    .REP_DLY(RD), .REP_PER(RP))
    dut_rep (.CLK(CLK), .RST_N(RST_N), .bus(bus_rep));
  btn_conditioner #(.NBTN(NB), .SMP_DIV(SD), .STABLE(ST), .REP_EN(0),
                    .REP_DLY(RD), .REP_PER(RP))
    dut_sgl (.CLK(CLK), .RST_N(RST_N), .bus(bus_sgl));

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input history, tick timestamps, ticks held since press.
  logic [NB-1:0] m_h1, m_h2;
  int            m_edge, m_tick_idx;
  int            m_last_ref [NB];
  int            m_held     [NB];
  logic [NB-1:0] m_lvl, m_out_rep, m_out_sgl, m_hold;
  logic [NB-1:0] prev_rep, prev_sgl;
  int            pulse_rep [NB];
  int            pulse_sgl [NB];

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_edge = 0; m_tick_idx = 0;
    m_lvl = '0; m_out_rep = '0; m_out_sgl = '0; m_hold = '0;
    prev_rep = '0; prev_sgl = '0;
    for (int c = 0; c < NB; c++) begin
      m_last_ref[c] = 0;
      m_held[c]     = 0;
    end
  endtask

  task automatic model_step(input logic [NB-1:0] b);
    logic [NB-1:0] smp;
    bit tk, toggled;
    smp = m_h2;
    tk  = (m_edge % SD) == (SD - 1);
    m_edge++;
    m_h2 = m_h1;
    m_h1 = b;
    m_out_rep = '0;
    m_out_sgl = '0;
    if (tk) begin
      m_tick_idx++;
      for (int c = 0; c < NB; c++) begin
        toggled = 0;
        if (smp[c] == m_lvl[c]) begin
          m_last_ref[c] = m_tick_idx;
        end else if (m_tick_idx - m_last_ref[c] >= ST) begin
          toggled       = 1;
          m_lvl[c]      = ~m_lvl[c];
          m_last_ref[c] = m_tick_idx;
          m_held[c]     = 0;
          if (m_lvl[c]) begin
            m_out_rep[c] = 1'b1;
            m_out_sgl[c] = 1'b1;
          end else begin
            m_hold[c] = 1'b0;
          end
        end
        if (!toggled && m_lvl[c]) begin
          m_held[c]++;
          if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0))
            m_out_rep[c] = 1'b1;
          m_hold[c] = (m_held[c] >= RD);
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("rep_lvl",  32'(bus_rep.BTNLVL),  32'(m_lvl));
    chk("rep_out",  32'(bus_rep.BTNOUT),  32'(m_out_rep));
    chk("rep_hold", 32'(bus_rep.BTNHOLD), 32'(m_hold));
    chk("sgl_lvl",  32'(bus_sgl.BTNLVL),  32'(m_lvl));
    chk("sgl_out",  32'(bus_sgl.BTNOUT),  32'(m_out_sgl));
    chk("sgl_hold", 32'(bus_sgl.BTNHOLD), 32'(0));
    chk("rep_out_back2back", 32'(prev_rep & bus_rep.BTNOUT), 32'(0));
    chk("sgl_out_back2back", 32'(prev_sgl & bus_sgl.BTNOUT), 32'(0));
    prev_rep = bus_rep.BTNOUT;
    prev_sgl = bus_sgl.BTNOUT;
    for (int c = 0; c < NB; c++) begin
      if (bus_rep.BTNOUT[c]) pulse_rep[c]++;
      if (bus_sgl.BTNOUT[c]) pulse_sgl[c]++;
    end
  endtask

  // One clock: drive just after an edge, model the next edge, sample 1 ns later.
  task automatic cycle(input logic [NB-1:0] b);
    btnin = b;
    @(posedge CLK);
    model_step(b);
    #1;
    compare_all();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NB; c++) begin
      pulse_rep[c] = 0;
      pulse_sgl[c] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_lvl"},  32'({bus_rep.BTNLVL,  bus_sgl.BTNLVL}),  32'(0));
    chk({tag, "_out"},  32'({bus_rep.BTNOUT,  bus_sgl.BTNOUT}),  32'(0));
    chk({tag, "_hold"}, 32'({bus_rep.BTNHOLD, bus_sgl.BTNHOLD}), 32'(0));
  endtask

  initial begin
    int lvl_seen, hold15, hold16, cnt;
    bit rose;
    logic [NB-1:0] v;

    // Power-on reset
    model_reset();
    clear_counts();
    repeat (3) @(negedge CLK);
    check_zero("por");
    RST_N = 1'b1;
    repeat (10) cycle(2'b00);

    // Bounce on channel 0, then a steady press
    clear_counts();
    lvl_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(((i / 3) % 2 == 0) ? 2'b01 : 2'b00);
      if (bus_rep.BTNLVL[0]) lvl_seen++;
    end
    chk("bounce_lvl_cycles", 32'(lvl_seen), 32'(0));
    repeat (40) cycle(2'b01);
    chk("bounce_press_pulses", 32'(pulse_sgl[0]), 32'(1));
    repeat (40) cycle(2'b00);

    // Short press without auto-repeat
    clear_counts();
    repeat (80) cycle(2'b01);
    chk("short_press_pulses", 32'(pulse_sgl[0]), 32'(1));
    repeat (40) cycle(2'b00);

    // Long press on channel 1 with auto-repeat
    clear_counts();
    rose = 0;
    for (int i = 0; i < 40 && !rose; i++) begin
      cycle(2'b10);
      rose = bus_rep.BTNLVL[1];
    end
    chk("long_rise_seen", 32'(rose), 32'(1));
    cnt = bus_rep.BTNOUT[1] ? 1 : 0;
    hold15 = 0;
    hold16 = 0;
    for (int k = 1; k <= 48; k++) begin
      cycle(2'b10);
      if (bus_rep.BTNOUT[1]) cnt++;
      if (k == 15) hold15 = bus_rep.BTNHOLD[1] ? 1 : 0;
      if (k == 16) hold16 = bus_rep.BTNHOLD[1] ? 1 : 0;
    end
    chk("long_pulses_12ticks", 32'(cnt), 32'(6));
    chk("long_hold_tick3", 32'(hold15), 32'(0));
    chk("long_hold_tick4", 32'(hold16), 32'(1));

    // Release while repeating, then re-press
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(2'b00);
      if (!bus_rep.BTNLVL[1] && bus_rep.BTNOUT[1]) cnt++;
    end
    chk("release_pulses", 32'(cnt), 32'(0));
    repeat (50) cycle(2'b10);
    repeat (30) cycle(2'b00);

    // Simultaneous press on both channels
    clear_counts();
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(2'b11);
      if (bus_rep.BTNOUT == 2'b11) cnt++;
    end
    chk("simul_both_pulse", 32'(cnt > 0), 32'(1));
    repeat (30) cycle(2'b00);

    // Randomised segments, including sub-STABLE glitches
    for (int s = 0; s < 60; s++) begin
      v = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 24)) cycle(v);
    end
    repeat (30) cycle(2'b00);

    // Asynchronous reset in the middle of a held press
    repeat (40) cycle(2'b11);
    #2;
    RST_N = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    clear_counts();
    repeat (3) @(negedge CLK);
    check_zero("in_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) cycle(2'b11);
    chk("post_rst_press_pulses", 32'(pulse_rep[0]), 32'(1));
    repeat (40) cycle(2'b11);
    repeat (30) cycle(2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
